// File: rtl/strela_csr_ctrl.sv
// STRELA CGRA control/status registers: stream descriptors, IDLE/CONFIG/EXEC sequencer,
// sticky done flags with W1C, masked interrupt and bus error reporting.
package strela_csr_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;
endpackage

module strela_csr_ctrl #(
   parameter type         reg_req_t = strela_csr_pkg::reg_req_t,
   parameter type         reg_rsp_t = strela_csr_pkg::reg_rsp_t,
   parameter int unsigned N_IN      = 4,
   parameter int unsigned N_OUT     = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  reg_req_t                 reg_req_i,
   output reg_rsp_t                 reg_rsp_o,
   output logic [N_IN-1:0][31:0]    data_input_addr_o,
   output logic [N_IN-1:0][15:0]    data_input_size_o,
   output logic [N_IN-1:0][15:0]    data_input_stride_o,
   output logic [N_OUT-1:0][31:0]   data_output_addr_o,
   output logic [N_OUT-1:0][15:0]   data_output_size_o,
   output logic [31:0]              data_config_addr_o,
   output logic [15:0]              data_config_size_o,
   input  logic                     done_config_i,
   input  logic                     done_exec_output_i,
   output logic                     load_configuration_o,
   output logic                     start_execution_o,
   output logic                     clear_cgra_o,
   output logic                     reset_state_machines_o,
   input  logic [31:0]              cycle_count_load_config_i,
   input  logic [31:0]              cycle_count_execute_i,
   input  logic [31:0]              cycle_count_stall_i,
   output logic                     irq_o
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SIZE_W = 16;

   typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_EXEC} state_e;

   state_e                        r_state, w_state_nxt;
   logic                          r_auto, w_auto_nxt;
   logic                          r_done_cfg, w_done_cfg_nxt;
   logic                          r_done_exec, w_done_exec_nxt;
   logic                          r_load, r_start, r_clear, r_rsm;
   logic                          w_load_nxt, w_start_nxt, w_clear_nxt, w_rsm_nxt;
   logic [1:0]                    r_irq_en;
   logic                          r_irq;
   logic [DATA_W-1:0]             r_cfg_addr;
   logic [SIZE_W-1:0]             r_cfg_size;
   logic [N_IN-1:0][DATA_W-1:0]   r_in_addr;
   logic [N_IN-1:0][DATA_W-1:0]   r_in_ss;
   logic [N_OUT-1:0][DATA_W-1:0]  r_out_addr;
   logic [N_OUT-1:0][SIZE_W-1:0]  r_out_size;

   logic [11:0]       w_off;
   logic [4:0]        w_idx;
   logic              w_aligned, w_hit_ctrl, w_hit_status, w_hit_irqen, w_hit_cfga, w_hit_cfgs;
   logic              w_hit_in, w_hit_out, w_hit_perf, w_hit_desc, w_mapped;
   logic              w_wr, w_err, w_wr_ok, w_ctrl_we, w_stat_we;
   logic [DATA_W-1:0] w_rdata;
   logic              w_unused_ok;

   // Byte-enable merge of a write into an existing register value
   function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

   assign w_off        = reg_req_i.addr[11:0];
   assign w_idx        = w_off[7:3];
   assign w_aligned    = (w_off[1:0] == 2'b00);
   assign w_hit_ctrl   = (w_off == 12'h000);
   assign w_hit_status = (w_off == 12'h004);
   assign w_hit_irqen  = (w_off == 12'h008);
   assign w_hit_cfga   = (w_off == 12'h00C);
   assign w_hit_cfgs   = (w_off == 12'h010);
   assign w_hit_in     = w_aligned && (w_off[11:8] == 4'h1) && (32'(w_idx) < N_IN);
   assign w_hit_out    = w_aligned && (w_off[11:8] == 4'h2) && (32'(w_idx) < N_OUT);
   assign w_hit_perf   = (w_off == 12'h300) || (w_off == 12'h304) || (w_off == 12'h308);
   assign w_hit_desc   = w_hit_cfga || w_hit_cfgs || w_hit_in || w_hit_out;
   assign w_mapped     = w_hit_ctrl || w_hit_status || w_hit_irqen || w_hit_desc || w_hit_perf;
   assign w_wr         = reg_req_i.valid && reg_req_i.write;
   // Descriptors are frozen while the fabric is configuring or running
   assign w_err        = reg_req_i.valid && (!w_mapped || (reg_req_i.write &&
                         (w_hit_perf || (w_hit_desc && (r_state != S_IDLE)))));
   assign w_wr_ok      = w_wr && !w_err;
   assign w_ctrl_we    = w_wr_ok && w_hit_ctrl && reg_req_i.wstrb[0];
   assign w_stat_we    = w_wr_ok && w_hit_status && reg_req_i.wstrb[0];
   assign w_unused_ok  = ^reg_req_i.addr[31:12];

   always_comb begin
      w_rdata = '0;
      if (w_hit_status) w_rdata = {28'b0, r_done_exec, r_done_cfg, r_state == S_EXEC, r_state == S_CONFIG};
      if (w_hit_irqen)  w_rdata = {30'b0, r_irq_en};
      if (w_hit_cfga)   w_rdata = r_cfg_addr;
      if (w_hit_cfgs)   w_rdata = {16'b0, r_cfg_size};
      for (int i = 0; i < N_IN; i++)
         if (w_hit_in && (w_idx == 5'(i))) w_rdata = w_off[2] ? r_in_ss[i] : r_in_addr[i];
      for (int i = 0; i < N_OUT; i++)
         if (w_hit_out && (w_idx == 5'(i))) w_rdata = w_off[2] ? {16'b0, r_out_size[i]} : r_out_addr[i];
      if (w_off == 12'h300) w_rdata = cycle_count_load_config_i;
      if (w_off == 12'h304) w_rdata = cycle_count_execute_i;
      if (w_off == 12'h308) w_rdata = cycle_count_stall_i;
   end

   always_comb begin
      reg_rsp_o       = '0;
      reg_rsp_o.ready = 1'b1;
      reg_rsp_o.error = w_err;
      reg_rsp_o.rdata = w_err ? '0 : w_rdata;
   end

   // Sequencer next state, sticky flags and command pulses
   always_comb begin
      w_state_nxt     = r_state;
      w_auto_nxt      = r_auto;
      w_done_cfg_nxt  = r_done_cfg;
      w_done_exec_nxt = r_done_exec;
      w_load_nxt      = 1'b0;
      w_start_nxt     = 1'b0;
      w_clear_nxt     = 1'b0;
      w_rsm_nxt       = 1'b0;
      if (w_stat_we && reg_req_i.wdata[2]) w_done_cfg_nxt  = 1'b0;
      if (w_stat_we && reg_req_i.wdata[3]) w_done_exec_nxt = 1'b0;
      if (w_ctrl_we && (reg_req_i.wdata[1] || reg_req_i.wdata[4])) begin
         w_clear_nxt = reg_req_i.wdata[1];
         w_rsm_nxt   = reg_req_i.wdata[4];
         w_state_nxt = S_IDLE;
         w_auto_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_ctrl_we && reg_req_i.wdata[2]) begin
                  w_load_nxt  = 1'b1;
                  w_auto_nxt  = reg_req_i.wdata[3];
                  w_state_nxt = S_CONFIG;
               end else if (w_ctrl_we && reg_req_i.wdata[0]) begin
                  w_start_nxt = 1'b1;
                  w_state_nxt = S_EXEC;
               end
            end
            S_CONFIG: begin
               if (done_config_i) begin
                  w_done_cfg_nxt = 1'b1;
                  w_auto_nxt     = 1'b0;
                  w_start_nxt    = r_auto;
                  w_state_nxt    = r_auto ? S_EXEC : S_IDLE;
               end
            end
            S_EXEC: begin
               if (done_exec_output_i) begin
                  w_done_exec_nxt = 1'b1;
                  w_state_nxt     = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_auto      <= 1'b0;
         r_done_cfg  <= 1'b0;
         r_done_exec <= 1'b0;
         r_load      <= 1'b0;
         r_start     <= 1'b0;
         r_clear     <= 1'b0;
         r_rsm       <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_auto      <= w_auto_nxt;
         r_done_cfg  <= w_done_cfg_nxt;
         r_done_exec <= w_done_exec_nxt;
         r_load      <= w_load_nxt;
         r_start     <= w_start_nxt;
         r_clear     <= w_clear_nxt;
         r_rsm       <= w_rsm_nxt;
         r_irq       <= |({r_done_exec, r_done_cfg} & r_irq_en);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_irq_en   <= '0;
         r_cfg_addr <= '0;
         r_cfg_size <= '0;
         r_in_addr  <= '0;
         r_in_ss    <= '0;
         r_out_addr <= '0;
         r_out_size <= '0;
      end else if (w_wr_ok) begin
         if (w_hit_irqen && reg_req_i.wstrb[0]) r_irq_en <= reg_req_i.wdata[1:0];
         if (w_hit_cfga) r_cfg_addr <= f_merge(r_cfg_addr, reg_req_i.wdata, reg_req_i.wstrb);
         if (w_hit_cfgs) r_cfg_size <= 16'(f_merge({16'b0, r_cfg_size}, reg_req_i.wdata, reg_req_i.wstrb));
         for (int i = 0; i < N_IN; i++) begin
            if (w_hit_in && (w_idx == 5'(i)) && !w_off[2])
               r_in_addr[i] <= f_merge(r_in_addr[i], reg_req_i.wdata, reg_req_i.wstrb);
            if (w_hit_in && (w_idx == 5'(i)) && w_off[2])
               r_in_ss[i] <= f_merge(r_in_ss[i], reg_req_i.wdata, reg_req_i.wstrb);
         end
         for (int i = 0; i < N_OUT; i++) begin
            if (w_hit_out && (w_idx == 5'(i)) && !w_off[2])
               r_out_addr[i] <= f_merge(r_out_addr[i], reg_req_i.wdata, reg_req_i.wstrb);
            if (w_hit_out && (w_idx == 5'(i)) && w_off[2])
               r_out_size[i] <= 16'(f_merge({16'b0, r_out_size[i]}, reg_req_i.wdata, reg_req_i.wstrb));
         end
      end
   end

   for (genvar g = 0; g < N_IN; g++) begin : g_in_ss
      assign data_input_size_o[g]   = r_in_ss[g][15:0];
      assign data_input_stride_o[g] = r_in_ss[g][31:16];
   end

   assign data_input_addr_o      = r_in_addr;
   assign data_output_addr_o     = r_out_addr;
   assign data_output_size_o     = r_out_size;
   assign data_config_addr_o     = r_cfg_addr;
   assign data_config_size_o     = r_cfg_size;
   assign load_configuration_o   = r_load;
   assign start_execution_o      = r_start;
   assign clear_cgra_o           = r_clear;
   assign reset_state_machines_o = r_rsm;
   assign irq_o                  = r_irq;
endmodule

// File: tb/tb_strela_csr_ctrl.sv
// Bench for strela_csr_ctrl (N_IN=2, N_OUT=3): bus reads and pulse events are scored
// against queues of expected results filled as stimulus is driven.
module tb_strela_csr_ctrl;
   import strela_csr_pkg::*;

   localparam int unsigned N_IN  = 2;
   localparam int unsigned N_OUT = 3;
   localparam int EV_LOAD  = 0;
   localparam int EV_START = 1 << 20;
   localparam int EV_CLR   = 2 << 20;
   localparam int EV_RSM   = 3 << 20;
   localparam logic [31:0] PERF0 = 32'hA5A5_0001;
   localparam logic [31:0] PERF1 = 32'hCAFE_0002;
   localparam logic [31:0] PERF2 = 32'h1234_0003;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_req_t req;
   reg_rsp_t rsp;
   logic [N_IN-1:0][31:0]  in_addr;
   logic [N_IN-1:0][15:0]  in_size, in_stride;
   logic [N_OUT-1:0][31:0] out_addr;
   logic [N_OUT-1:0][15:0] out_size;
   logic [31:0] cfg_addr;
   logic [15:0] cfg_size;
   logic done_cfg = 1'b0, done_exec = 1'b0;
   logic load, start, clr, rsm, irq;

   strela_csr_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp),
      .data_input_addr_o(in_addr), .data_input_size_o(in_size), .data_input_stride_o(in_stride),
      .data_output_addr_o(out_addr), .data_output_size_o(out_size),
      .data_config_addr_o(cfg_addr), .data_config_size_o(cfg_size),
      .done_config_i(done_cfg), .done_exec_output_i(done_exec),
      .load_configuration_o(load), .start_execution_o(start),
      .clear_cgra_o(clr), .reset_state_machines_o(rsm),
      .cycle_count_load_config_i(PERF0), .cycle_count_execute_i(PERF1),
      .cycle_count_stall_i(PERF2), .irq_o(irq));

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int exp_ev[$];
   int obs_ev[$];
   logic [32:0] rd_q[$];
   logic [32:0] exp_rd;
   logic [31:0] d;
   logic e;
   int c;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (load)  obs_ev.push_back(EV_LOAD + cyc);
      if (start) obs_ev.push_back(EV_START + cyc);
      if (clr)   obs_ev.push_back(EV_CLR + cyc);
      if (rsm)   obs_ev.push_back(EV_RSM + cyc);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s, output logic er);
      req.addr = a; req.wdata = wd; req.wstrb = s; req.write = 1'b1; req.valid = 1'b1;
      #1 er = rsp.error;
      @(negedge clk);
      req.valid = 1'b0; req.write = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] rd, output logic er);
      req.addr = a; req.write = 1'b0; req.wstrb = 4'h0; req.valid = 1'b1;
      #1 rd = rsp.rdata; er = rsp.error;
      req.valid = 1'b0;
   endtask

   task automatic test_reset();
      req = '0;
      idle(2);
      n_cmp++;
      if ({load, start, clr, rsm, irq} !== 5'b0) begin
         n_err++; $display("FAIL reset_outs got %b want 00000", {load, start, clr, rsm, irq});
      end
      n_cmp++;
      if (cfg_addr !== 32'h0) begin n_err++; $display("FAIL reset_cfg_addr got %h want 0", cfg_addr); end
      rst_n = 1'b1;
      idle(1);
      foreach (rd_q[i]) rd_q.delete(i);
      rd_q.push_back(33'h0); bus_rd(32'h100, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL rd_in_addr0 got %h want %h", {e, d}, exp_rd); end
      rd_q.push_back(33'h0); bus_rd(32'h204, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL rd_out_size0 got %h want %h", {e, d}, exp_rd); end
      rd_q.push_back(33'h0); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL rd_status_rst got %h want %h", {e, d}, exp_rd); end
      bus_wr(32'h104, 32'h0004_0050, 4'hF, e);
      rd_q.push_back({1'b0, 32'h0004_0050}); bus_rd(32'h104, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL rd_in_ss0 got %h want %h", {e, d}, exp_rd); end
      n_cmp++;
      if ({in_stride[0], in_size[0]} !== 32'h0004_0050) begin
         n_err++; $display("FAIL in_ss0_out got %h want 00040050", {in_stride[0], in_size[0]});
      end
   endtask

   task automatic test_auto_exec();
      c = cyc; bus_wr(32'h0, 32'h0C, 4'hF, e); exp_ev.push_back(EV_LOAD + c + 1);
      idle(4);
      c = cyc; done_cfg = 1'b1; @(negedge clk); done_cfg = 1'b0; exp_ev.push_back(EV_START + c + 1);
      rd_q.push_back({1'b0, 32'h6}); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL status_exec got %h want %h", {e, d}, exp_rd); end
      idle(2);
      done_exec = 1'b1; @(negedge clk); done_exec = 1'b0;
      rd_q.push_back({1'b0, 32'hC}); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL status_done got %h want %h", {e, d}, exp_rd); end
   endtask

   task automatic test_irq();
      bus_wr(32'h008, 32'h2, 4'hF, e);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency got %b want 0", irq); end
      idle(1);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set got %b want 1", irq); end
      bus_wr(32'h004, 32'h8, 4'hF, e);
      idle(1);
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c got %b want 0", irq); end
      rd_q.push_back({1'b0, 32'h4}); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL status_w1c got %h want %h", {e, d}, exp_rd); end
      c = cyc; bus_wr(32'h0, 32'h1, 4'hF, e); exp_ev.push_back(EV_START + c + 1);
      done_exec = 1'b1; bus_wr(32'h004, 32'h8, 4'h1, e); done_exec = 1'b0;
      rd_q.push_back({1'b0, 32'hC}); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL set_beats_w1c got %h want %h", {e, d}, exp_rd); end
      idle(1);
      n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_reassert got %b want 1", irq); end
   endtask

   task automatic test_errors();
      bus_wr(32'h004, 32'hC, 4'h1, e);
      c = cyc; bus_wr(32'h0, 32'h1, 4'hF, e); exp_ev.push_back(EV_START + c + 1);
      bus_wr(32'h10C, 32'h1234_5678, 4'hF, e);
      n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_desc_busy got %b want 1", e); end
      rd_q.push_back(33'h0); bus_rd(32'h10C, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL desc_unchanged got %h want %h", {e, d}, exp_rd); end
      rd_q.push_back({1'b1, 32'h0}); bus_rd(32'h3FC, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL err_unmapped got %h want %h", {e, d}, exp_rd); end
      rd_q.push_back({1'b1, 32'h0}); bus_rd(32'h110, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL err_chan_idx got %h want %h", {e, d}, exp_rd); end
      rd_q.push_back({1'b1, 32'h0}); bus_rd(32'h006, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL err_unaligned got %h want %h", {e, d}, exp_rd); end
      bus_wr(32'h300, 32'h1, 4'hF, e);
      n_cmp++; if (e !== 1'b1) begin n_err++; $display("FAIL err_perf_wr got %b want 1", e); end
      rd_q.push_back({1'b0, PERF1}); bus_rd(32'h304, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL rd_perf1 got %h want %h", {e, d}, exp_rd); end
      done_exec = 1'b1; @(negedge clk); done_exec = 1'b0;
      bus_wr(32'h10C, 32'h1234_5678, 4'hF, e);
      n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL err_desc_idle got %b want 0", e); end
      rd_q.push_back({1'b0, 32'h1234_5678}); bus_rd(32'h10C, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL rd_in_ss1 got %h want %h", {e, d}, exp_rd); end
      n_cmp++;
      if (in_stride[1] !== 16'h1234) begin n_err++; $display("FAIL in_stride1 got %h want 1234", in_stride[1]); end
   endtask

   task automatic test_clear();
      bus_wr(32'h004, 32'hC, 4'h1, e);
      c = cyc; bus_wr(32'h0, 32'h4, 4'hF, e); exp_ev.push_back(EV_LOAD + c + 1);
      rd_q.push_back({1'b0, 32'h1}); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL status_cfg got %h want %h", {e, d}, exp_rd); end
      c = cyc; bus_wr(32'h0, 32'h2, 4'hF, e); exp_ev.push_back(EV_CLR + c + 1);
      rd_q.push_back(33'h0); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL status_clr got %h want %h", {e, d}, exp_rd); end
      idle(2);
      done_cfg = 1'b1; @(negedge clk); done_cfg = 1'b0;
      rd_q.push_back(33'h0); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL done_idle_ign got %h want %h", {e, d}, exp_rd); end
      c = cyc; bus_wr(32'h0, 32'h10, 4'hF, e); exp_ev.push_back(EV_RSM + c + 1);
      c = cyc; bus_wr(32'h0, 32'h5, 4'hF, e); exp_ev.push_back(EV_LOAD + c + 1);
      idle(1);
      done_cfg = 1'b1; @(negedge clk); done_cfg = 1'b0;
      rd_q.push_back({1'b0, 32'h4}); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL load_wins got %h want %h", {e, d}, exp_rd); end
   endtask

   task automatic test_byte_enables();
      bus_wr(32'h00C, 32'h1122_3344, 4'hF, e);
      bus_wr(32'h00C, 32'h00AB_0000, 4'h4, e);
      rd_q.push_back({1'b0, 32'h11AB_3344}); bus_rd(32'h00C, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL byte_merge got %h want %h", {e, d}, exp_rd); end
      n_cmp++;
      if (cfg_addr !== 32'h11AB_3344) begin n_err++; $display("FAIL cfg_addr_out got %h want 11ab3344", cfg_addr); end
      bus_wr(32'h010, 32'hFFFF_BEEF, 4'h1, e);
      rd_q.push_back({1'b0, 32'h0000_00EF}); bus_rd(32'h010, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL cfg_size_be got %h want %h", {e, d}, exp_rd); end
      bus_wr(32'h0, 32'h4, 4'h2, e);
      idle(2);
      rd_q.push_back(33'h0 | 33'h4); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL ctrl_no_strb got %h want %h", {e, d}, exp_rd); end
   endtask

   task automatic test_async_reset();
      c = cyc; bus_wr(32'h0, 32'h4, 4'hF, e); exp_ev.push_back(EV_LOAD + c + 1);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({load, cfg_addr} !== 33'h0) begin
         n_err++; $display("FAIL async_rst got %b/%h want 0/0", load, cfg_addr);
      end
      @(negedge clk); rst_n = 1'b1;
      rd_q.push_back(33'h0); bus_rd(32'h004, d, e); exp_rd = rd_q.pop_front(); n_cmp++;
      if ({e, d} !== exp_rd) begin n_err++; $display("FAIL status_after_rst got %h want %h", {e, d}, exp_rd); end
      idle(2);
   endtask

   task automatic test_pulse_sequence();
      n_cmp++;
      if (obs_ev.size() !== exp_ev.size()) begin
         n_err++; $display("FAIL pulse_count got %0d want %0d", obs_ev.size(), exp_ev.size());
      end
      for (int i = 0; i < exp_ev.size(); i++) begin
         if (i < obs_ev.size()) begin
            n_cmp++;
            if (obs_ev[i] !== exp_ev[i]) begin
               n_err++; $display("FAIL pulse_%0d got kind %0d cyc %0d want kind %0d cyc %0d", i,
                                 obs_ev[i] >> 20, obs_ev[i] & 32'hFFFFF, exp_ev[i] >> 20, exp_ev[i] & 32'hFFFFF);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_auto_exec();
      test_irq();
      test_errors();
      test_clear();
      test_byte_enables();
      test_async_reset();
      test_pulse_sequence();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/strela_csr_ctrl.md
Name: strela_csr_ctrl

Overview:
Parametrised control/status register block for the STRELA CGRA, successor to the fixed 4x4 test CSR. It exposes per-channel input/output stream descriptors for N_IN/N_OUT channels, the configuration descriptor, and read-only performance counters. A sequencing FSM (IDLE/CONFIG/EXEC) issues load-config and start pulses, with optional auto-execute after configuration. It also provides sticky done flags (write-1-to-clear), a masked interrupt, and bus error reporting. It sits between the CVA6 register-interface bus and the CGRA memory nodes.

Parameters:
reg_req_t, logic, register-interface request type (addr, write, wdata, wstrb, valid)
reg_rsp_t, logic, register-interface response type (rdata, error, ready)
N_IN, 4, number of input channels (1..16)
N_OUT, 4, number of output channels (1..16)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
reg_req_i  in  reg_req_t  bus request
reg_rsp_o  out  reg_rsp_t  bus response
data_input_addr_o  out  32 x N_IN  input stream base addresses
data_input_size_o  out  16 x N_IN  input stream sizes
data_input_stride_o  out  16 x N_IN  input stream strides
data_output_addr_o  out  32 x N_OUT  output stream base addresses
data_output_size_o  out  16 x N_OUT  output stream sizes
data_config_addr_o  out  32  configuration bitstream address
data_config_size_o  out  16  configuration size
done_config_i  in  1  configuration-load complete pulse
done_exec_output_i  in  1  execution/output complete pulse
load_configuration_o  out  1  one-cycle config-load pulse
start_execution_o  out  1  one-cycle execute pulse
clear_cgra_o  out  1  one-cycle clear pulse
reset_state_machines_o  out  1  one-cycle debug reset pulse
cycle_count_load_config_i  in  32  perf counter
cycle_count_execute_i  in  32  perf counter
cycle_count_stall_i  in  32  perf counter
irq_o  out  1  level interrupt

Behaviour:
- Reset: all descriptor outputs 0, all pulse outputs 0, irq_o 0, FSM in IDLE, sticky flags 0, IRQ_EN 0, auto flag 0.
- Bus: ready always 1; reads are combinational from addr[11:0]; writes take effect on the clock edge when valid&write. Only aligned word addresses decode.
- Map:
  - 0x000 CTRL (W): bit0 start_exec, bit1 clear, bit2 load_config, bit3 auto_exec, bit4 reset_sm. Reads return 0.
  - 0x004 STATUS: R {28'b0, done_exec, done_cfg, busy_exec, busy_cfg}; writing 1 to bit2/bit3 clears the corresponding sticky flag.
  - 0x008 IRQ_EN: bit0 cfg, bit1 exec; R/W.
  - 0x00C CFG_ADDR; 0x010 CFG_SIZE (uses wdata[15:0]).
  - 0x100+8i IN_ADDR[i]; 0x104+8i {stride, size}[i], for i < N_IN.
  - 0x200+8i OUT_ADDR[i]; 0x204+8i OUT_SIZE[i], for i < N_OUT.
  - 0x300/0x304/0x308: perf counters, read-only.
- wstrb: descriptor and IRQ_EN writes honour byte enables. CTRL and STATUS act only if wstrb[0] is set.
- error=1 (same cycle, write discarded, rdata 0) in these cases:
  - unmapped or unaligned address;
  - channel index >= N_IN/N_OUT;
  - write to a perf counter;
  - write to any descriptor (0x00C..0x2FF) while FSM != IDLE.
- FSM:
  - IDLE + load_config: load_configuration_o=1 next cycle, latch auto=bit3, go CONFIG.
  - IDLE + start_exec (without load_config): start_execution_o=1 next cycle, go EXEC.
  - Both bits set: load_config wins. start_exec acts as auto only if bit3 is set.
  - CONFIG + done_config_i: set done_cfg. If auto, pulse start_execution_o next cycle and go EXEC; else go IDLE.
  - EXEC + done_exec_output_i: set done_exec, go IDLE.
  - start/load commands in CONFIG or EXEC are ignored (no error).
  - clear (any state): clear_cgra_o=1 next cycle, FSM to IDLE, auto cleared, sticky flags kept.
  - reset_sm behaves like clear but pulses reset_state_machines_o instead.
- Done pulses while IDLE are ignored. The sticky set wins over a same-cycle W1C.
- All pulse outputs are registered and high for exactly one cycle per accepted command.
- irq_o = |({done_exec, done_cfg} & IRQ_EN), registered (one-cycle latency).
- Async reset mid-operation: everything returns to reset values immediately, with no pulses emitted.

Test Plan:
- Reset, then read 0x100, 0x204, 0x004 -> all 0. Write 0x104=0x0004_0050, read back -> 0x00040050, data_input_stride_o[0]=4, data_input_size_o[0]=0x50.
- Write CTRL=0x0C, assert done_config_i 5 cycles later -> load pulse 1 cycle after the write, start pulse 1 cycle after done, STATUS=0x6 while in EXEC; done_exec_output_i -> STATUS=0xC.
- IRQ_EN=0x2 with done_exec set -> irq_o=1 one cycle later; write STATUS=0x8 -> irq_o=0. W1C in the same cycle as done_exec_output_i -> flag stays 1.
- Write 0x10C while EXEC -> error=1, value unchanged. Read 0x3FC (unmapped) -> error=1, rdata 0. With N_IN=2, access 0x110 -> error=1.
- Write CTRL=0x2 during CONFIG -> clear_cgra_o pulse, STATUS busy bits 0, a later done_config_i does not set done_cfg.
- Byte write to 0x00C with wstrb=0x4, wdata=0x00AB0000 over 0x11223344 -> readback 0x11AB3344.
